ks_pluck_sequencer: RTL and testbench
=====================================

// Module: ks_pluck_sequencer
// PURPOSE
//   Step sequencer that drives the Karplus-Strong string voice: plays a programmable pattern of
//   period values, issuing a pluck gate per step at a programmable tempo. Sits directly upstream
//   of the string voice and feeds its period and pluck inputs. The voice synchronises pluck over
//   2 flops and edge-detects it, so gate high/low times are guaranteed >= 2 cycles.
// PARAMETERS
//   DATA_WIDTH   8    width of period entries / period_o
//   STEPS        16   pattern depth (power of 2); IW = $clog2(STEPS)
//   TEMPO_WIDTH  16   width of tempo_i (step length counter)
//   GATE_WIDTH   8    width of gate_len_i
// PORTS
//   clk_i       in   1            clock
//   rst_ni      in   1            reset, asynchronous, active-low
//   run_i       in   1            1 = play continuously; 0 = stop at end of current step
//   step_i      in   1            single-cycle pulse: play exactly one step (honoured only in IDLE with run_i=0)
//   tempo_i     in   TEMPO_WIDTH  step length - 1 in clk cycles (effective min 7)
//   gate_len_i  in   GATE_WIDTH   pluck high time in cycles (clamped, see below)
//   loop_len_i  in   IW           index of last step in loop
//   wr_en_i     in   1            pattern write strobe
//   wr_addr_i   in   IW           pattern write address
//   wr_data_i   in   DATA_WIDTH   pattern entry; 0 = rest (no pluck)
//   period_o    out  DATA_WIDTH   period to string voice (registered)
//   pluck_o     out  1            pluck gate to string voice (registered)
//   step_idx_o  out  IW           index of step currently playing / next to play
//   busy_o      out  1            1 when state != IDLE
// BEHAVIOUR
//   - Reset (async, rst_ni=0): state IDLE, period_o=0, pluck_o=0, step_idx_o=0, busy_o=0,
//     counters 0, all pattern entries 0.
//   - step_len = max(tempo_i,7)+1 cycles. gate_eff = min(max(gate_len_i,2), step_len-2).
//     Both sampled at step start and held for the step.
//   - FSM IDLE/GATE/REST; one cycle counter cnt cleared at each step start.
//     IDLE: if run_i=1, or step_i=1 with run_i=0 -> fetch entry[step_idx]; entry!=0: period_o<=entry,
//       pluck_o<=1, ->GATE; entry==0: period_o held, pluck_o=0, ->REST. Outputs change on the edge
//       after the trigger cycle (latency 1). step_i while busy or while run_i=1 is ignored.
//     GATE: cnt==gate_eff-1 -> pluck_o<=0, ->REST.
//     REST: cnt==step_len-1 -> step_idx <= (step_idx>=loop_len_i) ? 0 : step_idx+1;
//       run_i=1: fetch new index same edge, ->GATE/REST; run_i=0: ->IDLE.
//   - period_o and pluck_o rise on the same edge; period_o never changes while pluck_o=1.
//   - run_i drop mid-step: current step completes in full (no truncated gate), then IDLE.
//   - loop_len_i lowered below step_idx: wrap to 0 at next advance. STEPS-1 wraps naturally.
//   - Write: takes effect next cycle. Write and fetch of same address in the same cycle: fetch
//     returns old entry. Writes allowed in every state.
//   - Rest step: pluck_o stays 0 for full step_len; consecutive plucks always separated by
//     >= 2 low cycles.
// STRUCTURE
//   - Shared package ks_pkg: FSM state enum, PLUCK_MIN_HIGH=2, PLUCK_MIN_LOW=2, TEMPO_MIN=7.
//   - Sub-module ks_pattern_ram: STEPS x DATA_WIDTH flop array, sync write, combinational read,
//     async clear. FSM, counter and clamp logic stay in the top.
// TESTING
//   1. Reset then run_i=1, tempo=15, gate=4, loop=3, pattern {40,50,60,70}: pluck high 4 / low 12
//      each step; period_o 40,50,60,70,40... on each pluck rise.
//   2. Pattern {40,0,60,0}: pluck only on steps 0 and 2; period_o stays 40 through step 1.
//   3. Clamps: tempo=2 -> step_len 8; gate=0 -> 2 high cycles; gate=200, tempo=9 -> 8 high, 2 low.
//   4. run_i=0, three step_i pulses (one mid-step, ignored): exactly two steps played,
//      step_idx_o 0->1->2, busy_o 0 between.
//   5. run_i dropped at cnt=1 of GATE: gate completes full length, IDLE after step_len; then
//      rst_ni low mid-step: outputs 0 asynchronously, pattern reads 0.
//   6. Write entry[1]=99 during step 1 -> not played until loop returns; same-cycle write/fetch of
//      step 2 plays old value. loop_len 7->1 while idx=5 -> next idx 0.

Source files
------------

// File: rtl/ks_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ks_pkg
//  Description : Shared FSM state type and pluck timing limits for the
//                Karplus-Strong pluck sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_REST = 2'd2
    } state_t;

    localparam int unsigned PLUCK_MIN_HIGH = 2;
    localparam int unsigned PLUCK_MIN_LOW  = 2;
    localparam int unsigned TEMPO_MIN      = 7;

endpackage
`default_nettype wire

// File: rtl/ks_pattern_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ks_pattern_ram
//  Description : STEPS x DATA_WIDTH flop array, synchronous write,
//                combinational read, asynchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_pattern_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STEPS      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [STEPS];
    logic [DATA_WIDTH-1:0] mem_d [STEPS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STEPS); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read sees the pre-write contents when a write targets the same address.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/ks_pluck_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ks_pluck_sequencer
//  Description : Step sequencer issuing period values and pluck gates to the
//                Karplus-Strong string voice at a programmable tempo.
//  Revision    : 1.0 - initial release
// ============================================================================
module ks_pluck_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STEPS       = 16,
    parameter int unsigned TEMPO_WIDTH = 16,
    parameter int unsigned GATE_WIDTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       run_i,
    input  logic                       step_i,
    input  logic [TEMPO_WIDTH-1:0]     tempo_i,
    input  logic [GATE_WIDTH-1:0]      gate_len_i,
    input  logic [$clog2(STEPS)-1:0]   loop_len_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(STEPS)-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    output logic [DATA_WIDTH-1:0]      period_o,
    output logic                       pluck_o,
    output logic [$clog2(STEPS)-1:0]   step_idx_o,
    output logic                       busy_o
);

    import ks_pkg::*;

    localparam int unsigned IW = $clog2(STEPS);
    localparam int unsigned CW = (TEMPO_WIDTH > GATE_WIDTH) ? TEMPO_WIDTH : GATE_WIDTH;

    state_t                state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [CW-1:0]         step_m1_q, step_m1_d;
    logic [CW-1:0]         gate_m1_q, gate_m1_d;
    logic [IW-1:0]         idx_q,    idx_d;
    logic [DATA_WIDTH-1:0] period_q, period_d;
    logic                  pluck_q,  pluck_d;

    logic [CW-1:0]         tempo_ext;
    logic [CW-1:0]         tempo_eff;
    logic [CW-1:0]         gate_ext;
    logic [CW-1:0]         gate_lo;
    logic [CW-1:0]         gate_lim;
    logic [CW-1:0]         gate_eff;
    logic                  step_end;
    logic [IW-1:0]         next_idx;
    logic [IW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  start_step;

    // Clamps guarantee >= PLUCK_MIN_HIGH high and >= PLUCK_MIN_LOW low cycles per step.
    assign tempo_ext = CW'(tempo_i);
    assign tempo_eff = (tempo_ext < CW'(TEMPO_MIN)) ? CW'(TEMPO_MIN) : tempo_ext;
    assign gate_ext  = CW'(gate_len_i);
    assign gate_lo   = (gate_ext < CW'(PLUCK_MIN_HIGH)) ? CW'(PLUCK_MIN_HIGH) : gate_ext;
    assign gate_lim  = tempo_eff - CW'(PLUCK_MIN_LOW - 1);
    assign gate_eff  = (gate_lo < gate_lim) ? gate_lo : gate_lim;

    assign step_end  = (cnt_q == step_m1_q);
    assign next_idx  = (idx_q >= loop_len_i) ? '0 : idx_q + IW'(1);
    assign rd_addr   = (state_q == ST_REST && step_end) ? next_idx : idx_q;

    ks_pattern_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEPS      (STEPS),
        .ADDR_WIDTH (IW)
    ) u_pattern_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_m1_d  = step_m1_q;
        gate_m1_d  = gate_m1_q;
        idx_d      = idx_q;
        period_d   = period_q;
        pluck_d    = pluck_q;
        start_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i || step_i) begin
                    start_step = 1'b1;
                end
            end
            ST_GATE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == gate_m1_q) begin
                    pluck_d = 1'b0;
                    state_d = ST_REST;
                end
            end
            ST_REST: begin
                cnt_d = cnt_q + CW'(1);
                if (step_end) begin
                    idx_d = next_idx;
                    if (run_i) begin
                        start_step = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pluck_d = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Timing is latched here so mid-step tempo/gate changes apply to the next step.
        if (start_step) begin
            cnt_d     = '0;
            step_m1_d = tempo_eff;
            gate_m1_d = gate_eff - CW'(1);
            if (rd_data != '0) begin
                period_d = rd_data;
                pluck_d  = 1'b1;
                state_d  = ST_GATE;
            end else begin
                pluck_d  = 1'b0;
                state_d  = ST_REST;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_m1_q <= '0;
            gate_m1_q <= '0;
            idx_q     <= '0;
            period_q  <= '0;
            pluck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_m1_q <= step_m1_d;
            gate_m1_q <= gate_m1_d;
            idx_q     <= idx_d;
            period_q  <= period_d;
            pluck_q   <= pluck_d;
        end
    end

    assign period_o   = period_q;
    assign pluck_o    = pluck_q;
    assign step_idx_o = idx_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ks_pluck_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ks_pluck_sequencer
//  Description : Directed self-checking bench with a step-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ks_pluck_sequencer;

    localparam int DW = 8, ST = 16, IW = 4, TW = 16, GW = 8, BOUND = 400;

    logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0, wr_en = 1'b0;
    logic [TW-1:0] tempo = 16'd15;
    logic [GW-1:0] gate_len = 8'd4;
    logic [IW-1:0] loop_len = 4'd3, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] period_o;
    logic          pluck_o, busy_o;
    logic [IW-1:0] step_idx_o;

    int n_vec = 0, n_err = 0, rise_cnt = 0;
    bit cmp_en = 1'b0;
    logic pluck_prev = 1'b0;

    always #5 clk = ~clk;

    ks_pluck_sequencer #(
        .DATA_WIDTH (DW), .STEPS (ST), .TEMPO_WIDTH (TW), .GATE_WIDTH (GW)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n), .run_i (run), .step_i (step),
        .tempo_i (tempo), .gate_len_i (gate_len), .loop_len_i (loop_len),
        .wr_en_i (wr_en), .wr_addr_i (wr_addr), .wr_data_i (wr_data),
        .period_o (period_o), .pluck_o (pluck_o), .step_idx_o (step_idx_o), .busy_o (busy_o)
    );

    // Reference model: a step is (entry, length, gate, position); the pluck is
    // high for the first 'gate' positions of a non-rest step.
    typedef struct packed {
        logic [31:0]   idx, pos, len, gl;
        logic          busy;
        logic [DW-1:0] ent, per;
    } mst_t;

    mst_t m;
    logic [DW-1:0] m_pat [ST];

    function automatic mst_t m_next(mst_t s);
        mst_t n;
        logic go;
        logic [31:0] t, g;
        n  = s;
        go = 1'b0;
        if (s.busy) begin
            n.pos = s.pos + 1;
            if (n.pos == s.len) begin
                n.idx = (s.idx >= 32'(loop_len)) ? 32'd0 : s.idx + 1;
                if (run) go = 1'b1;
                else     n.busy = 1'b0;
            end
        end else if (run || step) begin
            go = 1'b1;
        end
        if (go) begin
            n.ent  = m_pat[n.idx[IW-1:0]];
            t      = (32'(tempo) < 7) ? 32'd7 : 32'(tempo);
            n.len  = t + 1;
            g      = (32'(gate_len) < 2) ? 32'd2 : 32'(gate_len);
            n.gl   = (g < n.len - 2) ? g : n.len - 2;
            n.pos  = 0;
            n.busy = 1'b1;
            if (n.ent != 0) n.per = n.ent;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            for (int i = 0; i < ST; i++) m_pat[i] <= '0;
        end else begin
            m <= m_next(m);
            if (wr_en) m_pat[wr_addr] <= wr_data;
        end
    end

    task automatic cmp(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("pluck_o",    int'(pluck_o),    int'(m.busy && m.ent != 0 && m.pos < m.gl));
            cmp("period_o",   int'(period_o),   int'(m.per));
            cmp("step_idx_o", int'(step_idx_o), int'(m.idx));
            cmp("busy_o",     int'(busy_o),     int'(m.busy));
        end
    end

    always @(negedge clk) begin
        if (pluck_o && !pluck_prev) rise_cnt <= rise_cnt + 1;
        pluck_prev <= pluck_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; wr_en = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = IW'(a); wr_data = DW'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr4(input int d0, input int d1, input int d2, input int d3);
        wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy_o && n < BOUND) begin tick(); n++; end
        cmp({nm, "_idle"}, int'(busy_o), 0);
    endtask

    task automatic wait_idx(input string nm, input int want);
        int n;
        n = 0;
        while (int'(step_idx_o) != want && n < BOUND) begin tick(); n++; end
        cmp(nm, int'(step_idx_o), want);
    endtask

    // Call only right after a negedge; returns on the negedge of the next rise.
    task automatic pulse(output int per, output int hi, output int lo);
        int n;
        n = 0; per = -1; hi = 0; lo = 0;
        while (!pluck_o && n < BOUND) begin @(negedge clk); n++; end
        if (!pluck_o) begin
            cmp("pulse_timeout", 0, 1);
            return;
        end
        per = int'(period_o);
        while (pluck_o && hi < BOUND) begin hi++; @(negedge clk); end
        while (!pluck_o && lo < BOUND) begin lo++; @(negedge clk); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, hi, lo, r0, b;
        int exp1 [5] = '{40, 50, 60, 70, 40};
        int exp2 [4] = '{40, 60, 40, 60};
        int exp6 [5] = '{60, 70, 40, 99, 77};

        // Reset state
        tick();
        cmp_en = 1'b1;
        cmp("rst_period", int'(period_o), 0);
        cmp("rst_pluck",  int'(pluck_o), 0);
        cmp("rst_idx",    int'(step_idx_o), 0);
        cmp("rst_busy",   int'(busy_o), 0);
        rst_n = 1'b1;
        tick();

        // 1: continuous play, 4 high / 12 low
        wr4(40, 50, 60, 70);
        tempo = 16'd15; gate_len = 8'd4; loop_len = 4'd3;
        run = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            pulse(per, hi, lo);
            cmp("t1_period", per, exp1[k]);
            cmp("t1_high", hi, 4);
            cmp("t1_low", lo, 12);
        end
        tick();
        run = 1'b0;
        wait_idle("t1");

        // 2: rest steps keep period and stay low
        do_reset();
        wr(0, 40); wr(2, 60);
        run = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            pulse(per, hi, lo);
            cmp("t2_period", per, exp2[k]);
            cmp("t2_high", hi, 4);
            cmp("t2_low", lo, 28);
        end
        tick();
        run = 1'b0;
        wait_idle("t2");

        // 3: tempo and gate clamps
        do_reset();
        wr4(40, 50, 60, 70);
        tempo = 16'd2; gate_len = 8'd0;
        run = 1'b1;
        @(negedge clk);
        pulse(per, hi, lo);
        cmp("t3_min_high", hi, 2);
        cmp("t3_min_low", lo, 6);
        tempo = 16'd9; gate_len = 8'd200;
        pulse(per, hi, lo);
        cmp("t3_held_high", hi, 2);
        cmp("t3_held_low", lo, 6);
        pulse(per, hi, lo);
        cmp("t3_max_high", hi, 8);
        cmp("t3_max_low", lo, 2);
        cmp("t3_period", per, 60);
        tick();
        run = 1'b0;
        wait_idle("t3");
        tempo = 16'd15; gate_len = 8'd4;

        // 4: single-step pulses, mid-step pulse ignored
        do_reset();
        wr4(40, 50, 60, 70);
        cmp("t4_idx0", int'(step_idx_o), 0);
        r0 = rise_cnt;
        step = 1'b1; tick(); step = 1'b0;
        cmp("t4_busy", int'(busy_o), 1);
        ticks(5);
        step = 1'b1; tick(); step = 1'b0;
        wait_idle("t4a");
        cmp("t4_idx1", int'(step_idx_o), 1);
        ticks(3);
        cmp("t4_gap_busy", int'(busy_o), 0);
        step = 1'b1; tick(); step = 1'b0;
        wait_idle("t4b");
        cmp("t4_idx2", int'(step_idx_o), 2);
        cmp("t4_steps", rise_cnt - r0, 2);

        // 5: run dropped during gate, then async reset mid-step
        do_reset();
        wr4(40, 50, 60, 70);
        r0 = rise_cnt;
        run = 1'b1;
        b = 0;
        while (!pluck_o && b < BOUND) begin tick(); b++; end
        cmp("t5_rise", int'(pluck_o), 1);
        tick();
        run = 1'b0;
        hi = 2;
        while (pluck_o && hi < BOUND) begin tick(); if (pluck_o) hi++; end
        cmp("t5_high", hi, 4);
        b = 0;
        while (busy_o && b < BOUND) begin b++; tick(); end
        cmp("t5_tail", b, 12);
        cmp("t5_idx", int'(step_idx_o), 1);
        ticks(20);
        cmp("t5_one_step", rise_cnt - r0, 1);
        run = 1'b1;
        ticks(3);
        cmp("t5_mid_gate", int'(pluck_o), 1);
        #1 rst_n = 1'b0;
        #1;
        cmp("t5_arst_period", int'(period_o), 0);
        cmp("t5_arst_pluck",  int'(pluck_o), 0);
        cmp("t5_arst_idx",    int'(step_idx_o), 0);
        cmp("t5_arst_busy",   int'(busy_o), 0);
        ticks(2);
        rst_n = 1'b1;
        r0 = rise_cnt;
        ticks(40);
        cmp("t5_cleared_plucks", rise_cnt - r0, 0);
        cmp("t5_cleared_period", int'(period_o), 0);
        cmp("t5_cleared_busy", int'(busy_o), 1);
        run = 1'b0;
        wait_idle("t5");

        // 6: pattern writes while playing, loop length lowered
        do_reset();
        wr4(40, 50, 60, 70);
        run = 1'b1;
        wait_idx("t6_idx1", 1);
        wr(1, 99);
        ticks(14);
        wr(2, 77);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            pulse(per, hi, lo);
            cmp("t6_period", per, exp6[k]);
        end
        loop_len = 4'd7;
        tick();
        wait_idx("t6_idx5", 5);
        loop_len = 4'd1;
        b = 0;
        while (step_idx_o == 4'd5 && b < BOUND) begin tick(); b++; end
        cmp("t6_wrap", int'(step_idx_o), 0);
        run = 1'b0;
        wait_idle("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
